crp16_mmio_responder: RTL and testbench
=======================================

# crp16_mmio_responder

Memory-mapped I/O responder on the CRP16 datapath's data port (port b). Sits between the datapath and the dual-port RAM. Claims a 16-word I/O window at the top of the address space, which serves board LEDs, the hex value, switches, keys and a down-counting timer. Forwards every other access to RAM unchanged and returns read data with the same one-cycle latency as the synchronous RAM, so the datapath cannot tell I/O from memory.

## Interface
- IO_BASE, 16'hFFF0, base of the I/O window; the low 4 bits must be 0, and the window is IO_BASE..IO_BASE+15.
- SYNC_STAGES, 2, flip-flop depth of the SW/KEY synchronisers (minimum 2).

- clock  in  1  system clock, the same clock that drives the datapath and RAM.
- reset  in  1  asynchronous, active-high reset.
- cpu_address  in  16  datapath port-b address.
- cpu_data  in  16  datapath port-b write data.
- cpu_wren  in  1  datapath port-b write enable.
- cpu_q  out  16  read data returned to the datapath.
- mem_address  out  16  RAM port-b address.
- mem_data  out  16  RAM port-b write data.
- mem_wren  out  1  RAM port-b write enable.
- mem_q  in  16  RAM port-b read data.
- sw  in  10  raw board switches.
- key  in  4  raw board keys, active-low.
- ledr  out  10  LED register.
- hex_value  out  16  value for the hex display.

## Operation
- **Address decode:** `io_hit = (cpu_address[15:4] == IO_BASE[15:4])`.
- **RAM passthrough (combinational):**
  - mem_address = cpu_address and mem_data = cpu_data.
  - mem_wren = cpu_wren & ~io_hit; I/O writes never reach RAM.
- **Register map** (offset = cpu_address[3:0]):
  - 0x0 LED: R/W, bits 9:0; bits 15:10 read 0.
  - 0x1 HEX: R/W, 16 bits; drives hex_value.
  - 0x2 SW: read-only; synchronised sw in bits 9:0.
  - 0x3 KEY: read-only; bits 3:0 = ~synchronised key (1 = pressed).
  - 0x4 KEYEDGE: bit i is set on the press edge of key i (synchronised level goes 1 to 0). Writing 1 to a bit clears it (W1C).
  - 0x5 TCOUNT: R/W; the timer's current count.
  - 0x6 TPERIOD: R/W; the reload value.
  - 0x7 TCTRL:
    - bit0 EN, R/W.
    - bit1 AUTO, R/W.
    - bit15 EXP, set by hardware; writing 1 clears it (W1C).
    - All other bits read 0.
  - 0x8–0xF: read 0; writes are ignored.
- Reads have no side effects.
- **Timer**, evaluated each cycle when EN=1:
  - TCOUNT != 0: TCOUNT decrements by 1.
  - TCOUNT == 0: EXP is set. If AUTO=1, TCOUNT loads TPERIOD and EN stays 1. If AUTO=0, TCOUNT stays 0 and EN clears.
  - EN=0: TCOUNT holds.
  - Arithmetic is 16-bit unsigned with no underflow wrap.
- **Simultaneous events:**
  - A CPU write to TCOUNT or TCTRL.EN in the same cycle as a timer update: the CPU write wins.
  - A hardware set of EXP or a KEYEDGE bit in the same cycle as a W1C of that bit: the set wins.

## Timing
- Write: takes effect at the rising edge where cpu_wren=1; the new value is readable on the next cycle.
- Read: address is sampled at edge N and cpu_q is valid after edge N, i.e. one-cycle latency, matching RAM.
  - The responder registers io_sel_q = io_hit and io_rdata_q = the selected register at edge N.
  - cpu_q = io_sel_q ? io_rdata_q : mem_q.
- A read of a register in the same cycle it is written returns the old value.
- SW/KEY reach their registers SYNC_STAGES cycles after a pin change. A KEYEDGE bit sets 1 cycle after the synchronised level falls (edge detect against the previous synchronised sample).
- Timer: with EN=1 and TCOUNT=P, EXP sets P+1 cycles after EN is written.
- Reset (asynchronous, takes effect immediately):
  - All registers, synchronisers, io_sel_q and io_rdata_q go to 0; synchroniser flops for key reset to 1 (released).
  - ledr=0 and hex_value=0.
  - cpu_q follows mem_q.
  - mem_* remain a combinational passthrough.
  - A timer countdown in progress is aborted (EN=0). A read in flight is discarded.

## Test plan
- **RAM passthrough:** write 0x1234 to 0x0010, then read 0x0010. Expect mem_wren=1 on the write, and cpu_q=0x1234 one cycle after the read address.
- **I/O isolation:** write 0x03FF to 0xFFF0, then read 0xFFF0. Expect mem_wren=0, ledr=0x3FF and cpu_q=0x03FF. A write of 0xBEEF to 0xFFF1 gives hex_value=0xBEEF. A read of 0xFFF9 returns 0.
- **Timer one-shot:** write TCOUNT=3, then TCTRL=0x0001. Expect EXP set exactly 4 cycles after the TCTRL write edge, after which TCTRL reads 0x8000. Writing 0x8000 to TCTRL then makes it read 0x0000.
- **Timer auto-reload:** TPERIOD=2, TCOUNT=0, TCTRL=0x0003. Expect TCOUNT to sequence 2,1,0,2,… with EXP set on each zero. Issuing a W1C of EXP on the same cycle as a zero leaves EXP=1.
- **Keys:** drive key[2] low for 10 cycles with SYNC_STAGES=2.
  - KEY reads 0x0004 after 2 cycles; KEYEDGE reads 0x0004 and stays set after release.
  - Writing 0x0004 to KEYEDGE clears it.
  - sw=0x2A5 reads 0x02A5 from 0xFFF2.
- **Reset mid-operation:** assert reset while the timer counts from 0x0100 with LEDs at 0x155. Expect ledr=0 and TCTRL=0 immediately. After release the timer stays idle and RAM reads still return RAM data.

Source files
------------

// File: rtl/crp16_mmio_responder.sv
// CRP16 port-b MMIO responder: claims a 16-word I/O window and forwards all
// other accesses to RAM, matching the RAM's one-cycle read latency.
module crp16_mmio_responder #(
    parameter logic [15:0] IO_BASE     = 16'hFFF0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_cpu_address,
    input  logic [15:0] i_cpu_data,
    input  logic        i_cpu_wren,
    output logic [15:0] o_cpu_q,
    output logic [15:0] o_mem_address,
    output logic [15:0] o_mem_data,
    output logic        o_mem_wren,
    input  logic [15:0] i_mem_q,
    input  logic [9:0]  i_sw,
    input  logic [3:0]  i_key,
    output logic [9:0]  o_ledr,
    output logic [15:0] o_hex_value
);

    localparam logic [3:0] OFF_LED     = 4'h0;
    localparam logic [3:0] OFF_HEX     = 4'h1;
    localparam logic [3:0] OFF_SW      = 4'h2;
    localparam logic [3:0] OFF_KEY     = 4'h3;
    localparam logic [3:0] OFF_KEYEDGE = 4'h4;
    localparam logic [3:0] OFF_TCOUNT  = 4'h5;
    localparam logic [3:0] OFF_TPERIOD = 4'h6;
    localparam logic [3:0] OFF_TCTRL   = 4'h7;

    logic        w_io_hit;
    logic [3:0]  w_offset;
    logic        w_io_wr;
    logic        w_wr_led;
    logic        w_wr_hex;
    logic        w_wr_keyedge;
    logic        w_wr_tcount;
    logic        w_wr_tperiod;
    logic        w_wr_tctrl;

    logic [SYNC_STAGES-1:0][9:0] r_sw_sync;
    logic [SYNC_STAGES-1:0][3:0] r_key_sync;
    logic [9:0]  w_sw_s;
    logic [3:0]  w_key_s;
    logic [3:0]  r_key_prev;
    logic [3:0]  w_key_fall;
    logic [3:0]  r_keyedge;

    logic [9:0]  r_led;
    logic [15:0] r_hex;
    logic [15:0] r_tcount;
    logic [15:0] r_tperiod;
    logic        r_en;
    logic        r_auto;
    logic        r_exp;
    logic        w_fire;

    logic [15:0] w_rdata;
    logic        r_io_sel;
    logic [15:0] r_io_rdata;

    assign w_io_hit     = (i_cpu_address[15:4] == IO_BASE[15:4]);
    assign w_offset     = i_cpu_address[3:0];
    assign w_io_wr      = i_cpu_wren & w_io_hit;
    assign w_wr_led     = w_io_wr && (w_offset == OFF_LED);
    assign w_wr_hex     = w_io_wr && (w_offset == OFF_HEX);
    assign w_wr_keyedge = w_io_wr && (w_offset == OFF_KEYEDGE);
    assign w_wr_tcount  = w_io_wr && (w_offset == OFF_TCOUNT);
    assign w_wr_tperiod = w_io_wr && (w_offset == OFF_TPERIOD);
    assign w_wr_tctrl   = w_io_wr && (w_offset == OFF_TCTRL);

    assign o_mem_address = i_cpu_address;
    assign o_mem_data    = i_cpu_data;
    assign o_mem_wren    = i_cpu_wren & ~w_io_hit;

    // Key synchroniser flops reset to 1 so a reset never looks like a press.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sw_sync  <= '0;
            r_key_sync <= {SYNC_STAGES{4'hF}};
            r_key_prev <= 4'hF;
        end else begin
            r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], i_sw};
            r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], i_key};
            r_key_prev <= w_key_s;
        end
    end

    assign w_sw_s     = r_sw_sync[SYNC_STAGES-1];
    assign w_key_s    = r_key_sync[SYNC_STAGES-1];
    assign w_key_fall = r_key_prev & ~w_key_s;

    // A press edge in the same cycle as its W1C keeps the bit set.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_keyedge <= 4'h0;
        end else begin
            r_keyedge <= (r_keyedge & ~(w_wr_keyedge ? i_cpu_data[3:0] : 4'h0)) | w_key_fall;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_led     <= '0;
            r_hex     <= '0;
            r_tperiod <= '0;
            r_auto    <= 1'b0;
        end else begin
            if (w_wr_led)     r_led     <= i_cpu_data[9:0];
            if (w_wr_hex)     r_hex     <= i_cpu_data;
            if (w_wr_tperiod) r_tperiod <= i_cpu_data;
            if (w_wr_tctrl)   r_auto    <= i_cpu_data[1];
        end
    end

    assign w_fire = r_en && (r_tcount == 16'h0000);

    // CPU writes to TCOUNT/EN override the timer's own update.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tcount <= '0;
            r_en     <= 1'b0;
            r_exp    <= 1'b0;
        end else begin
            if (w_wr_tcount) begin
                r_tcount <= i_cpu_data;
            end else if (r_en) begin
                if (r_tcount != 16'h0000) begin
                    r_tcount <= r_tcount - 16'd1;
                end else if (r_auto) begin
                    r_tcount <= r_tperiod;
                end
            end

            if (w_wr_tctrl) begin
                r_en <= i_cpu_data[0];
            end else if (w_fire && !r_auto) begin
                r_en <= 1'b0;
            end

            r_exp <= (r_exp & ~(w_wr_tctrl & i_cpu_data[15])) | w_fire;
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        case (w_offset)
            OFF_LED:     w_rdata = {6'b0, r_led};
            OFF_HEX:     w_rdata = r_hex;
            OFF_SW:      w_rdata = {6'b0, w_sw_s};
            OFF_KEY:     w_rdata = {12'b0, ~w_key_s};
            OFF_KEYEDGE: w_rdata = {12'b0, r_keyedge};
            OFF_TCOUNT:  w_rdata = r_tcount;
            OFF_TPERIOD: w_rdata = r_tperiod;
            OFF_TCTRL:   w_rdata = {r_exp, 13'b0, r_auto, r_en};
            default:     w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_io_sel   <= 1'b0;
            r_io_rdata <= '0;
        end else begin
            r_io_sel   <= w_io_hit;
            r_io_rdata <= w_rdata;
        end
    end

    assign o_cpu_q     = r_io_sel ? r_io_rdata : i_mem_q;
    assign o_ledr      = r_led;
    assign o_hex_value = r_hex;

endmodule

// File: tb/tb_crp16_mmio_responder.sv
// Bench for crp16_mmio_responder: directed register-map scenarios followed by
// random bus traffic, all checked against a behavioural model of the I/O block.
module tb_crp16_mmio_responder;

    localparam int          SYNC  = 2;
    localparam logic [11:0] IO_HI = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_address = '0;
    logic [15:0] cpu_data = '0;
    logic        cpu_wren = 1'b0;
    logic [15:0] cpu_q;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;
    logic [9:0]  sw = '0;
    logic [3:0]  key = 4'hF;
    logic [9:0]  ledr;
    logic [15:0] hex_value;

    int n_cmp = 0;
    int n_err = 0;
    bit skip_q = 1'b0;

    always #5 clk = ~clk;

    crp16_mmio_responder #(.IO_BASE(16'hFFF0), .SYNC_STAGES(SYNC)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_cpu_address (cpu_address),
        .i_cpu_data    (cpu_data),
        .i_cpu_wren    (cpu_wren),
        .o_cpu_q       (cpu_q),
        .o_mem_address (mem_address),
        .o_mem_data    (mem_data),
        .o_mem_wren    (mem_wren),
        .i_mem_q       (mem_q),
        .i_sw          (sw),
        .i_key         (key),
        .o_ledr        (ledr),
        .o_hex_value   (hex_value)
    );

    // Synchronous RAM on the far side of the responder (read-old-data).
    logic [15:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    // Behavioural model state.
    logic [15:0] m_ram [0:65535];
    logic [9:0]  m_led;
    logic [15:0] m_hex, m_tcount, m_tperiod;
    logic        m_en, m_auto, m_exp;
    logic [3:0]  m_kedge, m_kprev;
    logic [9:0]  sw_q[$];
    logic [3:0]  key_q[$];

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_led = '0; m_hex = '0; m_tcount = '0; m_tperiod = '0;
        m_en = 1'b0; m_auto = 1'b0; m_exp = 1'b0;
        m_kedge = 4'h0; m_kprev = 4'hF;
        sw_q.delete();
        key_q.delete();
        for (int i = 0; i < SYNC; i++) begin
            sw_q.push_back(10'h000);
            key_q.push_back(4'hF);
        end
    endtask

    // One clock edge of the I/O block; rq is the read data for this edge.
    task automatic model_step(input logic [15:0] a, input logic [15:0] d, input logic we,
                              output logic [15:0] rq);
        logic       hit;
        logic [3:0] off, skey, fall;
        logic [9:0] ssw;
        logic [15:0] t_cnt;
        logic       t_en, fire;
        hit  = (a[15:4] == IO_HI);
        off  = a[3:0];
        ssw  = sw_q[0];
        skey = key_q[0];
        rq   = 16'h0000;
        if (hit) begin
            case (off)
                4'h0: rq = {6'b0, m_led};
                4'h1: rq = m_hex;
                4'h2: rq = {6'b0, ssw};
                4'h3: rq = {12'b0, ~skey};
                4'h4: rq = {12'b0, m_kedge};
                4'h5: rq = m_tcount;
                4'h6: rq = m_tperiod;
                4'h7: rq = {m_exp, 13'b0, m_auto, m_en};
                default: rq = 16'h0000;
            endcase
        end else begin
            rq = m_ram[a];
        end

        fire  = m_en && (m_tcount == 16'h0000);
        t_cnt = m_tcount;
        t_en  = m_en;
        if (m_en) begin
            if (m_tcount != 16'h0000) t_cnt = m_tcount - 16'd1;
            else if (m_auto)          t_cnt = m_tperiod;
            else                      t_en  = 1'b0;
        end
        fall = m_kprev & ~skey;

        if (we && hit) begin
            case (off)
                4'h0: m_led = d[9:0];
                4'h1: m_hex = d;
                4'h4: m_kedge = m_kedge & ~d[3:0];
                4'h5: t_cnt = d;
                4'h6: m_tperiod = d;
                4'h7: begin
                    t_en   = d[0];
                    m_auto = d[1];
                    if (d[15]) m_exp = 1'b0;
                end
                default: ;
            endcase
        end else if (we) begin
            m_ram[a] = d;
        end

        m_exp    = m_exp | fire;
        m_kedge  = m_kedge | fall;
        m_tcount = t_cnt;
        m_en     = t_en;
        m_kprev  = skey;
        sw_q.push_back(sw);
        void'(sw_q.pop_front());
        key_q.push_back(key);
        void'(key_q.pop_front());
    endtask

    // Starts and ends at a falling edge; one bus transaction per call.
    task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic we,
                         output logic [15:0] q_obs);
        logic [15:0] exp_q;
        logic        hit;
        cpu_address = a;
        cpu_data    = d;
        cpu_wren    = we;
        hit = (a[15:4] == IO_HI);
        #1;
        check_value("mem_wren", {15'b0, mem_wren}, {15'b0, we & ~hit});
        check_value("mem_address", mem_address, a);
        check_value("mem_data", mem_data, d);
        @(posedge clk);
        model_step(a, d, we, exp_q);
        #1;
        if (!skip_q) check_value("cpu_q", cpu_q, exp_q);
        check_value("ledr", {6'b0, ledr}, {6'b0, m_led});
        check_value("hex_value", hex_value, m_hex);
        q_obs = cpu_q;
        $display("txn a=%h d=%h we=%0d q=%h", a, d, we, q_obs);
        @(negedge clk);
    endtask

    logic [15:0] q, a, d;
    logic        we;
    int          r;
    logic [15:0] auto_seq [3];

    initial begin
        for (int i = 0; i < 65536; i++) m_ram[i] = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fill every RAM address the bench uses so reads never see unwritten words.
        skip_q = 1'b1;
        for (int i = 0; i < 64; i++) cycle(16'(i), 16'($urandom), 1'b1, q);
        cycle(16'hFFEF, 16'($urandom), 1'b1, q);
        skip_q = 1'b0;

        // RAM passthrough.
        cycle(16'h0010, 16'h1234, 1'b1, q);
        cycle(16'h0010, 16'h0000, 1'b0, q);
        check_value("ram_readback", q, 16'h1234);

        // I/O isolation.
        cycle(16'hFFF0, 16'h03FF, 1'b1, q);
        check_value("ledr_direct", {6'b0, ledr}, 16'h03FF);
        cycle(16'hFFF0, 16'h0000, 1'b0, q);
        check_value("led_readback", q, 16'h03FF);
        cycle(16'hFFF1, 16'hBEEF, 1'b1, q);
        check_value("hex_direct", hex_value, 16'hBEEF);
        cycle(16'hFFF9, 16'h0000, 1'b0, q);
        check_value("unmapped_read", q, 16'h0000);
        cycle(16'hFFEF, 16'h0000, 1'b0, q);

        // Timer one-shot: EXP appears on the 5th TCTRL read after enabling.
        cycle(16'hFFF5, 16'h0003, 1'b1, q);
        cycle(16'hFFF7, 16'h0001, 1'b1, q);
        for (int k = 1; k <= 4; k++) begin
            cycle(16'hFFF7, 16'h0000, 1'b0, q);
            check_value("oneshot_running", q, 16'h0001);
        end
        cycle(16'hFFF7, 16'h0000, 1'b0, q);
        check_value("oneshot_expired", q, 16'h8000);
        cycle(16'hFFF7, 16'h8000, 1'b1, q);
        cycle(16'hFFF7, 16'h0000, 1'b0, q);
        check_value("exp_w1c", q, 16'h0000);

        // Timer auto-reload, then a W1C colliding with a reload.
        cycle(16'hFFF6, 16'h0002, 1'b1, q);
        cycle(16'hFFF5, 16'h0000, 1'b1, q);
        cycle(16'hFFF7, 16'h0003, 1'b1, q);
        auto_seq[0] = 16'h0000; auto_seq[1] = 16'h0002; auto_seq[2] = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            cycle(16'hFFF5, 16'h0000, 1'b0, q);
            check_value("auto_count", q, auto_seq[k]);
        end
        cycle(16'hFFF7, 16'h8003, 1'b1, q);
        cycle(16'hFFF7, 16'h0000, 1'b0, q);
        check_value("exp_set_wins", q, 16'h8003);
        cycle(16'hFFF7, 16'h8000, 1'b1, q);
        cycle(16'hFFF7, 16'h0000, 1'b0, q);
        check_value("auto_stopped", q, 16'h0000);

        // Keys and switches.
        key = 4'b1011;
        for (int k = 0; k < 10; k++) cycle(16'hFFF3, 16'h0000, 1'b0, q);
        check_value("key_pressed", q, 16'h0004);
        key = 4'hF;
        for (int k = 0; k < 4; k++) cycle(16'hFFF3, 16'h0000, 1'b0, q);
        cycle(16'hFFF4, 16'h0000, 1'b0, q);
        check_value("keyedge_held", q, 16'h0004);
        cycle(16'hFFF4, 16'h0004, 1'b1, q);
        cycle(16'hFFF4, 16'h0000, 1'b0, q);
        check_value("keyedge_w1c", q, 16'h0000);
        sw = 10'h2A5;
        for (int k = 0; k < 3; k++) cycle(16'hFFF2, 16'h0000, 1'b0, q);
        check_value("sw_read", q, 16'h02A5);

        // Reset during a countdown.
        cycle(16'hFFF0, 16'h0155, 1'b1, q);
        cycle(16'hFFF5, 16'h0100, 1'b1, q);
        cycle(16'hFFF7, 16'h0001, 1'b1, q);
        for (int k = 0; k < 3; k++) cycle(16'hFFF5, 16'h0000, 1'b0, q);
        cpu_wren = 1'b0;
        rst = 1'b1;
        #1;
        check_value("reset_ledr", {6'b0, ledr}, 16'h0000);
        check_value("reset_hex", hex_value, 16'h0000);
        check_value("reset_cpu_q", cpu_q, mem_q);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cycle(16'hFFF7, 16'h0000, 1'b0, q);
        check_value("post_reset_tctrl", q, 16'h0000);
        cycle(16'hFFF5, 16'h0000, 1'b0, q);
        cycle(16'hFFF5, 16'h0000, 1'b0, q);
        check_value("post_reset_tcount", q, 16'h0000);
        cycle(16'h0010, 16'h0000, 1'b0, q);
        check_value("post_reset_ram", q, 16'h1234);

        // Random traffic against the model.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
            if ($urandom_range(0, 7) == 0)  key = 4'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 6)       a = {IO_HI, 4'($urandom)};
            else if (r == 6) a = 16'hFFEF;
            else             a = 16'($urandom_range(0, 63));
            we = 1'($urandom_range(0, 1));
            d  = (a == 16'hFFF5 || a == 16'hFFF6) ? 16'($urandom_range(0, 8)) : 16'($urandom);
            cycle(a, d, we, q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
